// File: rtl/ad7606_emu_pkg.sv
// AD7606 emulator shared types and helpers.
// Channel count, FSM states and oversampling decode.
package ad7606_emu_pkg;

  localparam int unsigned NUM_CH = 8;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  // Code 7 is reserved on the real part and behaves like no oversampling.
  function automatic logic [2:0] os_eff(
    input logic [2:0] os
  );
    return (os == 3'd7) ? 3'd0 : os;
  endfunction

endpackage

// File: rtl/ad7606_emu_if.sv
// Parallel-mode AD7606 pin bundle.
// master = ADC controller, slave = emulated ADC.
interface ad7606_emu_if;
  import ad7606_emu_pkg::*;

  logic        convstw_i;
  logic [2:0]  os_i;
  logic        cs_i;
  logic        rd_i;
  logic        busy_o;
  logic [15:0] db_o;
  logic        frstdata_o;

  modport master (
    output convstw_i,
    output os_i,
    output cs_i,
    output rd_i,
    input  busy_o,
    input  db_o,
    input  frstdata_o
  );

  modport slave (
    input  convstw_i,
    input  os_i,
    input  cs_i,
    input  rd_i,
    output busy_o,
    output db_o,
    output frstdata_o
  );

endinterface

// File: rtl/ad7606_emu.sv
// AD7606 8-channel ADC emulator, parallel read mode.
// Results encode conversion count and channel index.
module ad7606_emu
  import ad7606_emu_pkg::*;
#(
  parameter int unsigned T_CONV_CYCLES = 400,
  parameter int unsigned CNT_W         = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  ad7606_emu_if.slave   bus
);

  state_t      r_state;
  logic        r_convst_q;
  logic        r_rd_q;
  logic [CNT_W-1:0] r_timer;
  logic [12:0] r_cnt;
  logic [2:0]  r_ptr;
  logic [15:0] r_res [NUM_CH];
  logic        r_busy;
  logic [15:0] r_db;
  logic        r_frst;

  logic             w_conv_start;
  logic             w_rd_fall;
  logic [2:0]       w_rd_ptr;
  logic [CNT_W-1:0] w_load;

  assign w_conv_start = ~r_convst_q & bus.convstw_i
                      & (r_state == IDLE);
  assign w_rd_fall    = r_rd_q & ~bus.rd_i & ~bus.cs_i;
  // A conversion start in the same cycle claims the pointer first.
  assign w_rd_ptr     = w_conv_start ? 3'd0 : r_ptr;
  assign w_load       = CNT_W'(T_CONV_CYCLES)
                      << os_eff(bus.os_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_convst_q <= 1'b1;
      r_rd_q     <= 1'b1;
      r_timer    <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_busy     <= 1'b0;
      r_db       <= '0;
      r_frst     <= 1'b0;
      for (int k = 0; k < NUM_CH; k++)
        r_res[k] <= '0;
    end else begin
      r_convst_q <= bus.convstw_i;
      r_rd_q     <= bus.rd_i;
      unique case (r_state)
        IDLE: begin
          if (w_conv_start) begin
            r_state <= CONV;
            r_busy  <= 1'b1;
            r_timer <= w_load;
          end
        end
        CONV: begin
          if (r_timer == CNT_W'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= r_cnt + 13'd1;
            for (int k = 0; k < NUM_CH; k++)
              r_res[k] <= {r_cnt, 3'(k)};
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_rd_fall) begin
        r_db   <= r_res[w_rd_ptr];
        r_frst <= (w_rd_ptr == 3'd0);
        r_ptr  <= w_rd_ptr + 3'd1;
      end else if (w_conv_start) begin
        r_ptr  <= '0;
      end
    end
  end

  assign bus.busy_o     = r_busy;
  assign bus.db_o       = bus.cs_i ? 16'h0000 : r_db;
  assign bus.frstdata_o = ~bus.cs_i & r_frst;

endmodule

// File: tb/tb_ad7606_emu.sv
// Directed bench for the AD7606 emulator.
// Inputs change and outputs are sampled on the falling edge.
module tb_ad7606_emu;
  import ad7606_emu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ad7606_emu_if bus ();

  ad7606_emu #(
    .T_CONV_CYCLES (400),
    .CNT_W         (16)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_conv(
    input logic [2:0] os,
    input bit         glitch,
    input int         exp_w
  );
    int w;
    bus.os_i = os;
    chk("busy_idle", bus.busy_o, 0);
    bus.convstw_i = 1'b1;
    @(negedge clk);
    chk("busy_rise", bus.busy_o, 1);
    bus.convstw_i = 1'b0;
    w = 0;
    while (bus.busy_o && w < 40000) begin
      w++;
      if (glitch && w == 100) bus.convstw_i = 1'b1;
      if (glitch && w == 102) bus.convstw_i = 1'b0;
      @(negedge clk);
    end
    chk("busy_width", w, exp_w);
  endtask

  task automatic rd_read(
    input logic [15:0] ed,
    input logic        ef
  );
    bus.cs_i = 1'b0;
    bus.rd_i = 1'b0;
    @(negedge clk);
    chk("db", bus.db_o, 32'(ed));
    chk("frst", bus.frstdata_o, 32'(ef));
    @(negedge clk);
    bus.rd_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.convstw_i = 1'b0;
    bus.os_i      = 3'd0;
    bus.cs_i      = 1'b1;
    bus.rd_i      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.cs_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_db", bus.db_o, 0);
      chk("idle_frst", bus.frstdata_o, 0);
    end

    // First conversion: count 0 -> 0000..0007
    run_conv(3'd0, 1'b0, 400);
    for (int k = 0; k < 8; k++)
      rd_read(16'(k), k == 0);

    // Second conversion plus wrapping 9th read
    run_conv(3'd0, 1'b0, 400);
    for (int k = 0; k < 8; k++)
      rd_read(16'(8 + k), k == 0);
    rd_read(16'h0008, 1'b1);

    // os=3 with an ignored convst pulse mid-conversion
    run_conv(3'd3, 1'b1, 3200);

    // Reads with CS high are ignored
    bus.cs_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_i = 1'b0;
      @(negedge clk);
      chk("cs_hi_db", bus.db_o, 0);
      chk("cs_hi_frst", bus.frstdata_o, 0);
      bus.rd_i = 1'b1;
      @(negedge clk);
    end
    rd_read(16'h0010, 1'b1);

    // os=7 behaves as os=0
    run_conv(3'd7, 1'b0, 400);
    rd_read(16'h0018, 1'b1);
    rd_read(16'h0019, 1'b0);

    // Simultaneous convst rise and rd fall: read returns channel 0
    bus.cs_i      = 1'b0;
    bus.convstw_i = 1'b1;
    bus.rd_i      = 1'b0;
    @(negedge clk);
    chk("sim_db", bus.db_o, 32'h0018);
    chk("sim_frst", bus.frstdata_o, 1);
    chk("sim_busy", bus.busy_o, 1);
    bus.convstw_i = 1'b0;
    @(negedge clk);
    bus.rd_i = 1'b1;
    begin
      int w = 0;
      while (bus.busy_o && w < 1000) begin
        w++;
        @(negedge clk);
      end
      chk("sim_busy_end", bus.busy_o, 0);
    end
    rd_read(16'h0021, 1'b0);

    // Reset 200 cycles into a conversion
    bus.os_i      = 3'd0;
    bus.convstw_i = 1'b1;
    @(negedge clk);
    bus.convstw_i = 1'b0;
    repeat (199) @(negedge clk);
    chk("pre_rst_busy", bus.busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_db", bus.db_o, 0);
    chk("rst_frst", bus.frstdata_o, 0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(3'd0, 1'b0, 400);
    for (int k = 0; k < 8; k++)
      rd_read(16'(k), k == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ad7606_emu.md
Name: ad7606_emu

Overview:
- Synchronous, synthesizable emulator of an AD7606 8-channel, 16-bit simultaneous-sampling ADC.
- Converts on a CONVST rising edge and asserts BUSY for an oversampling-scaled conversion time.
- Delivers the 8 channel results in parallel-read mode via CS/RD strobes, with FRSTDATA marking channel 0.
- Used as a stand-in for the real part when verifying the ADC interface controller.

Parameters:
- T_CONV_CYCLES, 400, base conversion time in clk_i cycles (4 us at 100 MHz), used when os_i = 0.
- CNT_W, 16, width of the conversion timer; must hold T_CONV_CYCLES<<6.

Ports:
- clk_i  in  1  system clock; all inputs are sampled on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- convstw_i  in  1  conversion start; rising edge starts a conversion.
- os_i  in  3  oversampling ratio select, 2^os_i; values 7 and 0 both mean no oversampling.
- cs_i  in  1  chip select, active low.
- rd_i  in  1  read strobe, active low; falling edge advances the channel.
- busy_o  out  1  high while a conversion is in progress.
- db_o  out  16  channel data.
- frstdata_o  out  1  high while db_o holds channel 0.

Behaviour:
- Reset values: busy_o=0, db_o=16'h0000, frstdata_o=0. Read pointer=0, conversion count=0, result array all zero, edge-detect registers loaded with 1 (inactive).
- Edge detection: convstw_i and rd_i are each registered once; an edge is (prev, now) = (0,1) or (1,0). Inputs are synchronous to clk_i with a minimum pulse width of 1 cycle.
- IDLE -> CONV: on a detected convstw_i rising edge in cycle n with busy_o=0:
  - busy_o=1 from edge n+1.
  - Timer loads T_CONV_CYCLES << os_eff, where os_eff = os_i, or 0 when os_i = 7.
  - os_i is latched at the start of the conversion.
  - Read pointer is cleared to 0.
- CONV: timer decrements each cycle. busy_o stays high for exactly the loaded number of cycles, then returns to 0.
  - In the same cycle busy_o falls, result[k] = {conv_count[12:0], k[2:0]} for k = 0..7, and conv_count increments (13-bit wrap).
- convstw_i rising edges while busy_o=1 are ignored and do not restart the conversion.
- Read: on a detected rd_i falling edge while cs_i=0, the next cycle has db_o=result[ptr], frstdata_o=(ptr==0), and ptr increments mod 8.
  - A 9th read wraps to channel 0 and asserts frstdata_o again.
  - db_o holds its value until the next read.
- Reads while busy_o=1 are permitted and return the previous conversion's results.
- When cs_i is high: rd_i edges are ignored, db_o is driven 16'h0000, and frstdata_o=0. ptr is kept, so the next CS-low sequence continues from ptr.
- Reset asserted mid-conversion or mid-read aborts the operation immediately. All state returns to its reset values. No result is stored and conv_count is not incremented.
- Simultaneous convst rising edge and rd falling edge in IDLE: the conversion start wins the pointer, so ptr is cleared. The read in that same cycle returns channel 0.

Decomposition:
- Package ad7606_emu_pkg holds:
  - NUM_CH=8.
  - State enum {IDLE, CONV}.
  - Function os_eff(os) mapping 7 to 0.
- No sub-module needed. The edge detectors are two inline flops; the timer and the 8x16 result register array live in the top.

Test Plan:
- Reset then idle: busy_o=0, db_o=0, frstdata_o=0 throughout 10 cycles with no strobes.
- os_i=0, convst low for 5 cycles then high: busy_o rises 1 cycle after the rising edge and is high exactly 400 cycles. Then CS low with 8 RD pulses (2 cycles low each) gives db_o = 0000,0001,...,0007, with frstdata_o high only for the first.
- Second conversion, same 8 reads -> 0008..000F. A 9th read wraps to 0008 with frstdata_o=1.
- os_i=3: busy_o high exactly 3200 cycles. A convst pulse mid-conversion leaves busy_o width unchanged. os_i=7 gives 400 cycles.
- RD pulses with cs_i=1: db_o stays 0 and ptr is unchanged. A subsequent CS-low read returns channel 0.
- reset_i pulsed at cycle 200 of a conversion: busy_o=0 next cycle. The next conversion's reads return 0000..0007.
